upsample_interp: RTL and testbench

Rate-restoring interpolator for the two-channel (g/f) ECG sample stream, sitting on the far side of the decimation stage. It accepts decimated sample pairs on a valid/ready handshake, buffers them in a 2-entry FIFO, and emits L = 2^LOG2_L output pairs per input pair on `clk_enable` cycles. It uses linear interpolation between consecutive inputs, or zero-order hold when configured out. It reports sticky overflow and underrun flags for the monitoring controller.

---
 rtl/upsample_interp_if.sv | 25 ++
 rtl/upsample_interp.sv | 217 +++++++++++++++++++++
 tb/tb_upsample_interp.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upsample_interp_if.sv
// Sample-pair stream bundle for upsample_interp.
//   in_valid/in_ready/in_g/in_f : decimated input pairs (valid/ready handshake)
//   out_valid/out_g/out_f       : interpolated output pairs (one-cycle valid pulses)
// Modports: master = sample source / output sink, slave = interpolator.
interface upsample_interp_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_g;
  logic [DATA_W-1:0] in_f;
  logic              out_valid;
  logic [DATA_W-1:0] out_g;
  logic [DATA_W-1:0] out_f;

  modport master (
    output in_valid, in_g, in_f,
    input  in_ready, out_valid, out_g, out_f
  );

  modport slave (
    input  in_valid, in_g, in_f,
    output in_ready, out_valid, out_g, out_f
  );
endinterface

// File: rtl/upsample_interp.sv
// Rate-restoring interpolator for the two-channel (g/f) ECG stream.
// Buffers decimated pairs in a 2-entry FIFO and emits 2^LOG2_L output pairs
// per input pair on clk_enable cycles.
// Ports:
//   clk, reset (async, active-high), clk_enable (output-rate enable)
//   bus (upsample_interp_if.slave): input handshake + registered outputs
//   overflow : sticky, in_valid seen while FIFO full
//   underrun : sticky, FIFO empty at a phase wrap
// Build option: define UPSAMPLE_INTERP_EN for linear interpolation; without
// it the block is a zero-order hold (y = x0) with no subtract/multiply.
module upsample_interp #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2_L = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  upsample_interp_if.slave bus,
  output logic             overflow,
  output logic             underrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [LOG2_L-1:0]       phase_q, phase_d;
  logic [1:0][DATA_W-1:0]  mem_g_q, mem_g_d;
  logic [1:0][DATA_W-1:0]  mem_f_q, mem_f_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    in_ready_q, in_ready_d;
  logic [DATA_W-1:0]       x0_g_q, x0_g_d, x1_g_q, x1_g_d;
  logic [DATA_W-1:0]       x0_f_q, x0_f_d, x1_f_q, x1_f_d;
  logic [DATA_W-1:0]       out_g_q, out_g_d, out_f_q, out_f_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overflow_q, overflow_d;
  logic                    underrun_q, underrun_d;

  logic                    push;
  logic                    pop;
  logic                    non_empty;
  logic [DATA_W-1:0]       head_g, head_f;
  logic [DATA_W-1:0]       y_g, y_f;

`ifdef UPSAMPLE_INTERP_EN
  localparam int unsigned DW1 = DATA_W + 1;
  localparam int unsigned PW  = DATA_W + 1 + LOG2_L;

  // y = x0 + floor((x1 - x0) * phase / L); result stays between x0 and x1
  function automatic logic [DATA_W-1:0] interp(input logic [DATA_W-1:0] a0,
                                                input logic [DATA_W-1:0] a1,
                                                input logic [LOG2_L-1:0] ph);
    logic signed [DW1-1:0] diff;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  sum;
    diff = DW1'($signed(a1)) - DW1'($signed(a0));
    prod = PW'(diff) * $signed(PW'({1'b0, ph}));
    sum  = PW'($signed(a0)) + (prod >>> LOG2_L);
    return DATA_W'(sum);
  endfunction

  always_comb begin
    y_g = interp(x0_g_q, x1_g_q, phase_q);
    y_f = interp(x0_f_q, x1_f_q, phase_q);
  end
`else
  // Zero-order hold: every phase repeats the current sample
  always_comb begin
    y_g = x0_g_q;
    y_f = x0_f_q;
  end
`endif

  assign head_g    = mem_g_q[rd_ptr_q];
  assign head_f    = mem_f_q[rd_ptr_q];
  assign non_empty = (count_q != 2'd0);
  assign push      = bus.in_valid && in_ready_q;

  // Next-state: FIFO, sequencer, datapath registers and flags
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    mem_g_d     = mem_g_q;
    mem_f_d     = mem_f_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    x0_g_d      = x0_g_q;
    x0_f_d      = x0_f_q;
    x1_g_d      = x1_g_q;
    x1_f_d      = x1_f_q;
    out_g_d     = out_g_q;
    out_f_d     = out_f_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underrun_d  = underrun_q;
    pop         = 1'b0;

    if (bus.in_valid && !in_ready_q) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      mem_g_d[wr_ptr_q] = bus.in_g;
      mem_f_d[wr_ptr_q] = bus.in_f;
      wr_ptr_d          = ~wr_ptr_q;
    end

    if (clk_enable) begin
      case (state_q)
        IDLE: begin
          if (non_empty) begin
            pop     = 1'b1;
            state_d = PRIME;
          end
        end
        PRIME: begin
          if (non_empty) begin
            pop     = 1'b1;
            phase_d = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          out_g_d     = y_g;
          out_f_d     = y_f;
          out_valid_d = 1'b1;
          if (phase_q != '1) begin
            phase_d = phase_q + LOG2_L'(1);
          end else if (non_empty) begin
            pop     = 1'b1;
            phase_d = '0;
          end else begin
            underrun_d = 1'b1;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          out_g_d     = x1_g_q;
          out_f_d     = x1_f_q;
          out_valid_d = 1'b1;
          if (non_empty) begin
            pop     = 1'b1;
            phase_d = '0;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // IDLE only loads x1; every later pop shifts the pair window
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      x1_g_d   = head_g;
      x1_f_d   = head_f;
      if (state_q != IDLE) begin
        x0_g_d = x1_g_q;
        x0_f_d = x1_f_q;
      end
    end

    count_d    = count_q + 2'(push) - 2'(pop);
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      mem_g_q     <= '0;
      mem_f_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      x0_g_q      <= '0;
      x0_f_q      <= '0;
      x1_g_q      <= '0;
      x1_f_q      <= '0;
      out_g_q     <= '0;
      out_f_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      mem_g_q     <= mem_g_d;
      mem_f_q     <= mem_f_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      x0_g_q      <= x0_g_d;
      x0_f_q      <= x0_f_d;
      x1_g_q      <= x1_g_d;
      x1_f_q      <= x1_f_d;
      out_g_q     <= out_g_d;
      out_f_q     <= out_f_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_g     = out_g_q;
  assign bus.out_f     = out_f_q;
  assign bus.out_valid = out_valid_q;
  assign overflow      = overflow_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_upsample_interp.sv
// Directed bench for upsample_interp: L=2 instance for fill, interpolation,
// starvation/HOLD, overflow and mid-run reset; L=4 instance for full-scale slope.
// Expected values follow the build option UPSAMPLE_INTERP_EN.
module tb_upsample_interp;

  localparam int unsigned DATA_W = 16;
`ifdef UPSAMPLE_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en1 = 1'b0;
  logic en2 = 1'b0;
  logic ovf1, und1, ovf2, und2;

  always #5 clk = ~clk;

  upsample_interp_if #(.DATA_W(DATA_W)) b1 ();
  upsample_interp_if #(.DATA_W(DATA_W)) b2 ();

  upsample_interp #(.DATA_W(DATA_W), .LOG2_L(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (en1),
    .bus        (b1.slave),
    .overflow   (ovf1),
    .underrun   (und1)
  );

  upsample_interp #(.DATA_W(DATA_W), .LOG2_L(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (en2),
    .bus        (b2.slave),
    .overflow   (ovf2),
    .underrun   (und2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q1g[$], q1f[$], q2g[$], q2f[$];
  int first1 = -1;
  int last_push = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Output capture, mid-cycle
  always @(negedge clk) begin
    if (b1.out_valid) begin
      q1g.push_back(int'($signed(b1.out_g)));
      q1f.push_back(int'($signed(b1.out_f)));
      if (first1 < 0) first1 = cyc;
    end
    if (b2.out_valid) begin
      q2g.push_back(int'($signed(b2.out_g)));
      q2f.push_back(int'($signed(b2.out_f)));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int qsize(input int which);
    return (which == 1) ? q1g.size() : q2g.size();
  endfunction

  function automatic int getq(input int which, input bit f_ch, input int i);
    if (i >= qsize(which)) return 32'h7fff_ffff;
    if (which == 1) return f_ch ? q1f[i] : q1g[i];
    return f_ch ? q2f[i] : q2g[i];
  endfunction

  task automatic clear_q();
    q1g.delete(); q1f.delete(); q2g.delete(); q2f.delete();
    first1 = -1;
  endtask

  task automatic push(input int which, input int g, input int f);
    if (which == 1) begin
      b1.in_valid = 1'b1; b1.in_g = DATA_W'(g); b1.in_f = DATA_W'(f);
    end else begin
      b2.in_valid = 1'b1; b2.in_g = DATA_W'(g); b2.in_f = DATA_W'(f);
    end
    @(posedge clk);
    tick();
    last_push   = cyc;
    b1.in_valid = 1'b0;
    b2.in_valid = 1'b0;
  endtask

  task automatic wait_q(input int which, input int n, input int budget);
    int i = 0;
    while (qsize(which) < n && i < budget) begin
      tick();
      i++;
    end
    check("outputs_arrived", int'(qsize(which) >= n), 1);
  endtask

  task automatic check_seq(input string tag, input int which, input int n,
                           input int eg[6], input int ef[6]);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_g%0d", tag, i), getq(which, 1'b0, i), eg[i]);
      check($sformatf("%s_f%0d", tag, i), getq(which, 1'b1, i), ef[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_q();
  endtask

  initial begin
    int eg[6];
    int ef[6];
    int p2;

    b1.in_valid = 1'b0; b1.in_g = '0; b1.in_f = '0;
    b2.in_valid = 1'b0; b2.in_g = '0; b2.in_f = '0;
    tick();
    tick();

    // Reset values
    check("rst_out_g", int'(b1.out_g), 0);
    check("rst_out_valid", int'(b1.out_valid), 0);
    check("rst_in_ready", int'(b1.in_ready), 1);
    check("rst_overflow", int'(ovf1), 0);
    check("rst_underrun", int'(und1), 0);
    reset = 1'b0;
    clear_q();

    // L=4 full-scale slope, no wrap-around
    en2 = 1'b1;
    push(2, -32768, 100);
    tick();
    push(2, 32767, -100);
    wait_q(2, 4, 30);
    if (INTERP) begin
      eg = '{-32768, -16385, -1, 16383, 0, 0};
      ef = '{100, 50, 0, -50, 0, 0};
    end else begin
      eg = '{-32768, -32768, -32768, -32768, 0, 0};
      ef = '{100, 100, 100, 100, 0, 0};
    end
    check_seq("l4", 2, 4, eg, ef);
    check("l4_overflow", int'(ovf2), 0);
    en2 = 1'b0;

    // Rate-matched stream: one pair every 2 enabled cycles
    do_reset();
    en1 = 1'b1;
    p2 = 0;
    for (int k = 0; k < 6; k++) begin
      push(1, 100 * k, 1000 - 100 * k);
      if (k == 1) p2 = last_push;
      tick();
    end
    check("rate_underrun", int'(und1), 0);
    check("rate_overflow", int'(ovf1), 0);
    wait_q(1, 10, 40);
    check("fill_latency", first1 - p2, 2);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("rate_g%0d", k), getq(1, 1'b0, k),
            INTERP ? 50 * k : 100 * (k / 2));
      check($sformatf("rate_f%0d", k), getq(1, 1'b1, k),
            INTERP ? 1000 - 50 * k : 1000 - 100 * (k / 2));
    end

    // Negative slope rounds toward minus infinity
    do_reset();
    push(1, 0, 5);
    tick();
    push(1, -3, 8);
    wait_q(1, 2, 20);
    if (INTERP) begin
      eg = '{0, -2, 0, 0, 0, 0};
      ef = '{5, 6, 0, 0, 0, 0};
    end else begin
      eg = '{0, 0, 0, 0, 0, 0};
      ef = '{5, 5, 0, 0, 0, 0};
    end
    check_seq("neg", 1, 2, eg, ef);

    // Starvation after 3 pairs, then recovery through HOLD
    do_reset();
    push(1, 0, 0);
    tick();
    push(1, 10, -10);
    tick();
    push(1, 20, -20);
    wait_q(1, 6, 40);
    if (INTERP) begin
      eg = '{0, 5, 10, 15, 20, 20};
      ef = '{0, -5, -10, -15, -20, -20};
    end else begin
      eg = '{0, 0, 10, 10, 20, 20};
      ef = '{0, 0, -10, -10, -20, -20};
    end
    check_seq("starve", 1, 6, eg, ef);
    check("starve_underrun", int'(und1), 1);
    tick();
    tick();
    clear_q();
    push(1, 40, -40);
    wait_q(1, 5, 20);
    if (INTERP) begin
      eg = '{20, 20, 20, 30, 40, 0};
      ef = '{-20, -20, -20, -30, -40, 0};
    end else begin
      eg = '{20, 20, 20, 20, 40, 0};
      ef = '{-20, -20, -20, -20, -40, 0};
    end
    check_seq("resume", 1, 5, eg, ef);
    check("resume_overflow", int'(ovf1), 0);

    // Overflow with clk_enable low: third pair dropped
    do_reset();
    en1 = 1'b0;
    push(1, 10, 1);
    check("ovf_ready1", int'(b1.in_ready), 1);
    push(1, 30, 3);
    check("ovf_ready2", int'(b1.in_ready), 0);
    push(1, 99, 9);
    check("ovf_flag", int'(ovf1), 1);
    check("ovf_ready3", int'(b1.in_ready), 0);
    tick();
    tick();
    check("ovf_no_output", qsize(1), 0);
    check("ovf_underrun", int'(und1), 0);
    en1 = 1'b1;
    wait_q(1, 4, 30);
    if (INTERP) begin
      eg = '{10, 20, 30, 30, 0, 0};
      ef = '{1, 2, 3, 3, 0, 0};
    end else begin
      eg = '{10, 10, 30, 30, 0, 0};
      ef = '{1, 1, 3, 3, 0, 0};
    end
    check_seq("ovf", 1, 4, eg, ef);
    check("ovf_ready_after", int'(b1.in_ready), 1);
    check("ovf_still_set", int'(ovf1), 1);

    // Asynchronous reset while RUN is emitting
    push(1, 50, 5);
    tick();
    check("pre_reset_valid", int'(b1.out_valid), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_g", int'(b1.out_g), 0);
    check("mid_rst_out_f", int'(b1.out_f), 0);
    check("mid_rst_valid", int'(b1.out_valid), 0);
    check("mid_rst_ready", int'(b1.in_ready), 1);
    check("mid_rst_overflow", int'(ovf1), 0);
    check("mid_rst_underrun", int'(und1), 0);
    tick();
    reset = 1'b0;
    clear_q();
    push(1, 7, 70);
    tick();
    push(1, 9, 90);
    p2 = last_push;
    wait_q(1, 2, 20);
    check("restart_latency", first1 - p2, 2);
    if (INTERP) begin
      eg = '{7, 8, 0, 0, 0, 0};
      ef = '{70, 80, 0, 0, 0, 0};
    end else begin
      eg = '{7, 7, 0, 0, 0, 0};
      ef = '{70, 70, 0, 0, 0, 0};
    end
    check_seq("restart", 1, 2, eg, ef);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
